// File: rtl/dls_pkg.sv
// dls_pkg: shared definitions for the dummy line sequencer.
//   - one-hot FSM state encoding
//   - counter widths for the sample, gap and line counters
//   - legality check for the frame geometry parameters
package dls_pkg;

  localparam int SAMP_W = 16;
  localparam int GAP_W  = 8;
  localparam int LINE_W = 8;

  // One-hot encoding; each state owns exactly one bit.
  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_ARM  = 5'b00010,
    ST_LINE = 5'b00100,
    ST_GAP  = 5'b01000,
    ST_FIN  = 5'b10000
  } state_e;

  // True when the frame geometry fits the counter widths above.
  function automatic bit params_legal(int samples, int lines, int gap);
    return (samples >= 1) && (samples <= 65535) &&
           (lines   >= 1) && (lines   <= 256)   &&
           (gap     >= 0) && (gap     <= 255);
  endfunction

endpackage

// File: rtl/dls_tc_counter.sv
// dls_tc_counter: generic up-counter that wraps to zero after reaching TC.
//   clk    : clock
//   clr_i  : synchronous clear (highest priority)
//   en_i   : count enable
//   cnt_o  : current count
//   tc_o   : high while the count equals the terminal value TC
module dls_tc_counter #(
  parameter int             W  = 8,
  parameter logic [W-1:0]   TC = '0
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      // Wrapping at TC lets the owner reuse the counter line after line.
      cnt_d = (cnt_q == TC) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == TC);

endmodule

// File: rtl/dummy_line_sequencer.sv
// dummy_line_sequencer: frames the external 16-bit test-pattern counter into
// LINES scan lines of SAMPLES samples, separated by GAP idle cycles, and
// presents them as a valid/ready stream.
//   CLK, CLR        : clock and synchronous active-high reset
//   START, ABORT    : host frame request / frame abort
//   CNT_Q           : pattern counter value (in)
//   CNT_nCLR        : pattern counter clear, active-low, registered
//   CNT_nEN         : pattern counter enable, active-low, combinational
//   DATA_OUT, VALID, READY, SOF, EOL, LINE_IDX : output stream
//   BUSY, DONE      : frame in progress / one-cycle completion pulse
module dummy_line_sequencer
  import dls_pkg::*;
#(
  parameter int SAMPLES = 256,
  parameter int LINES   = 64,
  parameter int GAP     = 16
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              START,
  input  logic              ABORT,
  input  logic [15:0]       CNT_Q,
  output logic              CNT_nCLR,
  output logic              CNT_nEN,
  output logic [15:0]       DATA_OUT,
  output logic              VALID,
  input  logic              READY,
  output logic              SOF,
  output logic              EOL,
  output logic [LINE_W-1:0] LINE_IDX,
  output logic              BUSY,
  output logic              DONE
);

  generate
    if (!params_legal(SAMPLES, LINES, GAP)) begin : g_bad_params
      $error("dummy_line_sequencer: SAMPLES/LINES/GAP out of range");
    end
  endgenerate

  localparam logic [SAMP_W-1:0] SAMP_TC = SAMP_W'(SAMPLES - 1);
  localparam logic [LINE_W-1:0] LINE_TC = LINE_W'(LINES - 1);
  // GAP=0 never enters the gap state, so its terminal value is irrelevant.
  localparam logic [GAP_W-1:0]  GAP_TC  = GAP_W'((GAP == 0) ? 0 : GAP - 1);

  state_e state_q;
  state_e state_d;
  logic   cnt_nclr_q;
  logic   cnt_nclr_d;

  logic              in_line;
  logic              in_idle;
  logic              beat;
  logic              cnt_clr;
  logic [SAMP_W-1:0] samp_cnt;
  logic              samp_tc;
  logic [GAP_W-1:0]  gap_cnt_unused;
  logic              gap_tc;
  logic [LINE_W-1:0] line_cnt;
  logic              line_tc;

  assign in_line = (state_q == ST_LINE);
  assign in_idle = (state_q == ST_IDLE);
  assign beat    = in_line && READY;
  // Counters are held at zero while idle so every frame starts clean.
  assign cnt_clr = CLR || in_idle;

  dls_tc_counter #(.W(SAMP_W), .TC(SAMP_TC)) u_samp_cnt (
    .clk   (CLK),
    .clr_i (cnt_clr),
    .en_i  (beat),
    .cnt_o (samp_cnt),
    .tc_o  (samp_tc)
  );

  dls_tc_counter #(.W(GAP_W), .TC(GAP_TC)) u_gap_cnt (
    .clk   (CLK),
    .clr_i (cnt_clr),
    .en_i  (state_q == ST_GAP),
    .cnt_o (gap_cnt_unused),
    .tc_o  (gap_tc)
  );

  // The line index stops at LINES-1 so it stays valid through FIN.
  dls_tc_counter #(.W(LINE_W), .TC(LINE_TC)) u_line_cnt (
    .clk   (CLK),
    .clr_i (cnt_clr),
    .en_i  (beat && samp_tc && !line_tc),
    .cnt_o (line_cnt),
    .tc_o  (line_tc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (START && !ABORT) state_d = ST_ARM;
      end
      ST_ARM: begin
        state_d = ABORT ? ST_IDLE : ST_LINE;
      end
      ST_LINE: begin
        if (ABORT) begin
          state_d = ST_IDLE;
        end else if (beat && samp_tc) begin
          if (line_tc)       state_d = ST_FIN;
          else if (GAP > 0)  state_d = ST_GAP;
          else               state_d = ST_LINE;
        end
      end
      ST_GAP: begin
        if (ABORT)       state_d = ST_IDLE;
        else if (gap_tc) state_d = ST_LINE;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Pulse the pattern clear while ARM is the current state.
    cnt_nclr_d = (state_d != ST_ARM);
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q    <= ST_IDLE;
      cnt_nclr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_nclr_q <= cnt_nclr_d;
    end
  end

  assign CNT_nCLR = cnt_nclr_q;
  assign CNT_nEN  = ~beat;
  assign DATA_OUT = CNT_Q;
  assign VALID    = in_line;
  assign SOF      = in_line && (line_cnt == '0) && (samp_cnt == '0);
  assign EOL      = in_line && samp_tc;
  assign LINE_IDX = line_cnt;
  assign BUSY     = !in_idle;
  assign DONE     = (state_q == ST_FIN);

endmodule
